// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply MAC sequencer.
// Holds the FSM state encoding, operand/product widths and an accumulator width helper.
// Pure declarations; no logic of its own.
package matmul_pkg;

    localparam int DATA_W = 8;
    localparam int MUL_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Smallest accumulator that holds N full-scale products without wrapping.
    function automatic int min_acc_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return MUL_W + w;
    endfunction

endpackage

// File: rtl/matmul_mac_sequencer_if.sv
// Block-level control plus A/B read ports and C write port of the MAC sequencer.
// master = sequencer side, slave = memory/controller side.
// Memory reads return data one cycle after the enable.
interface matmul_mac_sequencer_if #(
    parameter int ACC_W = 18,
    parameter int AW    = 4
);
    logic             ap_start;
    logic             ap_done;
    logic             ap_idle;
    logic             ap_ready;
    logic [AW-1:0]    a_address0;
    logic             a_ce0;
    logic [7:0]       a_q0;
    logic [AW-1:0]    b_address0;
    logic             b_ce0;
    logic [7:0]       b_q0;
    logic [AW-1:0]    c_address0;
    logic             c_ce0;
    logic             c_we0;
    logic [ACC_W-1:0] c_d0;

    modport master (
        input  ap_start, a_q0, b_q0,
        output ap_done, ap_idle, ap_ready,
        output a_address0, a_ce0, b_address0, b_ce0,
        output c_address0, c_ce0, c_we0, c_d0
    );

    modport slave (
        output ap_start, a_q0, b_q0,
        input  ap_done, ap_idle, ap_ready,
        input  a_address0, a_ce0, b_address0, b_ce0,
        input  c_address0, c_ce0, c_we0, c_d0
    );
endinterface

// File: rtl/matmul_seq_mul_u8.sv
// Unsigned 8x8 -> 16 multiplier shared by every MAC step.
// Latency: purely combinational, no pipeline stage.
// No flow control; output follows inputs.
module matmul_seq_mul_u8
    import matmul_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [MUL_W-1:0]  p
);
    // Operands zero-extended so the product is the full unsigned result.
    assign p = {{(MUL_W-DATA_W){1'b0}}, a} * {{(MUL_W-DATA_W){1'b0}}, b};
endmodule

// File: rtl/matmul_mac_sequencer.sv
// Computes C = A x B (N x N, 8-bit unsigned) through one shared multiplier.
// Latency: N+2 cycles per C element, ap_done in cycle N*N*(N+2)+1 after start.
// No backpressure: memories are assumed always ready; ap_start ignored while busy.
module matmul_mac_sequencer
    import matmul_pkg::*;
#(
    parameter int N     = 3,
    parameter int ACC_W = 18,
    parameter int AW    = $clog2(N*N)
) (
    input logic                    ap_clk,
    input logic                    ap_rst_n,
    matmul_mac_sequencer_if.master bus
);
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N-1);

    // Reject parameter sets that could overflow or that the indexing cannot cover.
    generate
        if (ACC_W < min_acc_w(N)) begin : g_bad_acc_w
            $error("ACC_W too narrow for N: products could wrap");
        end
        if (N < 2 || N > 16) begin : g_bad_n
            $error("N must lie in 2..16");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CW-1:0]    i_q, i_d;
    logic [CW-1:0]    j_q, j_d;
    logic [CW-1:0]    k_q, k_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             mac_v_q, mac_v_d;
    logic [MUL_W-1:0] prod;

    // Read data arrives the cycle after the fetch, so the product of the
    // previous fetch is available now and gated by mac_v_q.
    matmul_seq_mul_u8 u_mul (
        .a (bus.a_q0),
        .b (bus.b_q0),
        .p (prod)
    );

    function automatic logic [AW-1:0] flat_addr(input logic [CW-1:0] r,
                                                input logic [CW-1:0] c);
        return AW'(int'(r) * N + int'(c));
    endfunction

    // Result data always shows the live accumulator.
    assign bus.c_d0 = acc_q;

    // Next-state, loop indices, accumulator and memory/handshake outputs.
    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        j_d            = j_q;
        k_d            = k_q;
        mac_v_d        = 1'b0;
        acc_d          = acc_q;
        bus.a_ce0      = 1'b0;
        bus.b_ce0      = 1'b0;
        bus.a_address0 = '0;
        bus.b_address0 = '0;
        bus.c_ce0      = 1'b0;
        bus.c_we0      = 1'b0;
        bus.c_address0 = '0;
        bus.ap_done    = 1'b0;
        bus.ap_ready   = 1'b0;
        bus.ap_idle    = 1'b0;

        if (mac_v_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        case (state_q)
            S_IDLE: begin
                bus.ap_idle = 1'b1;
                if (bus.ap_start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.a_ce0      = 1'b1;
                bus.b_ce0      = 1'b1;
                bus.a_address0 = flat_addr(i_q, k_q);
                bus.b_address0 = flat_addr(k_q, j_q);
                mac_v_d        = 1'b1;
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                bus.c_ce0      = 1'b1;
                bus.c_we0      = 1'b1;
                bus.c_address0 = flat_addr(i_q, j_q);
                acc_d          = '0;
                if (i_q == LAST && j_q == LAST) begin
                    state_d = S_DONE;
                end else if (j_q == LAST) begin
                    j_d     = '0;
                    i_d     = i_q + CW'(1);
                    state_d = S_FETCH;
                end else begin
                    j_d     = j_q + CW'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                bus.ap_done  = 1'b1;
                bus.ap_ready = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            mac_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            mac_v_q <= mac_v_d;
        end
    end

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// Scoreboard bench for matmul_mac_sequencer: N=3/ACC_W=18 and N=2/ACC_W=17 instances.
// Expected writes and ap_done cycles are queued at start; monitors pop on c_we0/ap_done.
// Directed vectors with hand-computed results.
module tb_matmul_mac_sequencer;
    import matmul_pkg::*;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   edge_cnt = 0;
    int   checks = 0;
    int   passed = 0;

    wr_t  exp3[$];
    wr_t  exp2[$];
    int   done3[$];
    int   done2[$];

    logic [7:0] mem_a[9];
    logic [7:0] mem_b[9];
    int         exp_c[9];
    int         e0;

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    matmul_mac_sequencer_if #(.ACC_W(18), .AW(4)) bus3 ();
    matmul_mac_sequencer_if #(.ACC_W(17), .AW(2)) bus2 ();

    matmul_mac_sequencer #(.N(3), .ACC_W(18), .AW(4)) dut3 (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus3)
    );

    matmul_mac_sequencer #(.N(2), .ACC_W(17), .AW(2)) dut2 (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus2)
    );

    // One-cycle-latency read models.
    always @(posedge clk) begin
        if (bus3.a_ce0) bus3.a_q0 <= mem_a[bus3.a_address0];
        if (bus3.b_ce0) bus3.b_q0 <= mem_b[bus3.b_address0];
        if (bus2.a_ce0) bus2.a_q0 <= 8'hFF;
        if (bus2.b_ce0) bus2.b_q0 <= 8'hFF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor for the N=3 instance.
    always @(negedge clk) begin
        wr_t e;
        int  d;
        if (bus3.c_we0) begin
            if (exp3.size() == 0) begin
                checks++;
                $display("FAIL c3_write: unexpected write addr %0d data %0d", bus3.c_address0, bus3.c_d0);
            end else begin
                e = exp3.pop_front();
                check("c3_addr", 32'(bus3.c_address0), 32'(e.addr));
                check("c3_data", 32'(bus3.c_d0), 32'(e.data));
                check("c3_ce", 32'(bus3.c_ce0), 32'd1);
            end
        end
        if (bus3.ap_done) begin
            if (done3.size() == 0) begin
                checks++;
                $display("FAIL done3: unexpected ap_done at edge %0d", edge_cnt);
            end else begin
                d = done3.pop_front();
                check("done3_cycle", 32'(edge_cnt), 32'(d));
                check("ready3", 32'(bus3.ap_ready), 32'd1);
            end
        end
    end

    // Monitor for the N=2 instance.
    always @(negedge clk) begin
        wr_t e;
        int  d;
        if (bus2.c_we0) begin
            if (exp2.size() == 0) begin
                checks++;
                $display("FAIL c2_write: unexpected write addr %0d data %0d", bus2.c_address0, bus2.c_d0);
            end else begin
                e = exp2.pop_front();
                check("c2_addr", 32'(bus2.c_address0), 32'(e.addr));
                check("c2_data", 32'(bus2.c_d0), 32'(e.data));
            end
        end
        if (bus2.ap_done) begin
            if (done2.size() == 0) begin
                checks++;
                $display("FAIL done2: unexpected ap_done at edge %0d", edge_cnt);
            end else begin
                d = done2.pop_front();
                check("done2_cycle", 32'(edge_cnt), 32'(d));
            end
        end
    end

    // Sample ap_start at edge E0; returns in cycle 1 with expectations queued.
    task automatic begin_run3(input bit hold);
        @(negedge clk);
        bus3.ap_start = 1'b1;
        @(posedge clk);
        #1;
        e0 = edge_cnt;
        if (!hold) bus3.ap_start = 1'b0;
        for (int n = 0; n < 9; n++) exp3.push_back('{addr: n, data: exp_c[n]});
        done3.push_back(e0 + 45);
        check("idle3_after_start", 32'(bus3.ap_idle), 32'd0);
        check("first_fetch_ce", 32'(bus3.a_ce0 & bus3.b_ce0), 32'd1);
    endtask

    task automatic wait_all(input string name);
        int t;
        t = 0;
        while ((exp3.size() + exp2.size() + done3.size() + done2.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            $display("FAIL %s: timeout, %0d writes and %0d done still pending", name,
                     exp3.size() + exp2.size(), done3.size() + done2.size());
            exp3.delete(); exp2.delete(); done3.delete(); done2.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int dedge;
        int t;
        bus3.ap_start = 1'b0;
        bus2.ap_start = 1'b0;
        bus3.a_q0 = '0; bus3.b_q0 = '0;
        bus2.a_q0 = '0; bus2.b_q0 = '0;

        // Reset state
        #12;
        check("rst_idle", 32'(bus3.ap_idle), 32'd1);
        check("rst_ce", 32'({bus3.a_ce0, bus3.b_ce0, bus3.c_ce0, bus3.c_we0}), 32'd0);
        check("rst_addr", 32'({bus3.a_address0, bus3.b_address0, bus3.c_address0}), 32'd0);
        check("rst_cd0", 32'(bus3.c_d0), 32'd0);
        check("rst_done", 32'({bus3.ap_done, bus3.ap_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Identity A, B = 1..9 -> C = B
        mem_a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        mem_b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        exp_c = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        begin_run3(1'b0);
        check("first_fetch_addr", 32'({bus3.a_address0, bus3.b_address0}), 32'd0);
        wait_all("identity");

        // All 255 operands: 3*255*255 = 195075
        for (int n = 0; n < 9; n++) begin
            mem_a[n] = 8'hFF;
            mem_b[n] = 8'hFF;
            exp_c[n] = 195075;
        end
        begin_run3(1'b0);
        wait_all("saturate");

        // General values, with a stray ap_start pulse while busy
        mem_a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        mem_b = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        exp_c = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        begin_run3(1'b0);
        repeat (10) @(negedge clk);
        bus3.ap_start = 1'b1;
        @(negedge clk);
        bus3.ap_start = 1'b0;
        wait_all("general");

        // ap_start held: next run fetches 2 cycles after ap_done
        begin_run3(1'b1);
        t = 0;
        while (!bus3.ap_done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            $display("FAIL b2b_done: ap_done not seen within 100 cycles");
        end
        dedge = edge_cnt;
        for (int n = 0; n < 9; n++) exp3.push_back('{addr: n, data: exp_c[n]});
        done3.push_back(dedge + 2 + 45);
        @(negedge clk);
        check("b2b_gap_ce", 32'(bus3.a_ce0), 32'd0);
        check("b2b_gap_idle", 32'(bus3.ap_idle), 32'd1);
        @(negedge clk);
        check("b2b_second_fetch", 32'(bus3.a_ce0), 32'd1);
        check("b2b_busy", 32'(bus3.ap_idle), 32'd0);
        bus3.ap_start = 1'b0;
        wait_all("back_to_back");

        // Reset asserted in cycle 20 (a write cycle) aborts the run
        begin_run3(1'b0);
        repeat (19) @(posedge clk);
        #2;
        check("mid_we_before_rst", 32'(bus3.c_we0), 32'd1);
        check("mid_writes_done", 32'(exp3.size()), 32'd6);
        exp3.delete();
        done3.delete();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ce", 32'({bus3.a_ce0, bus3.b_ce0, bus3.c_ce0, bus3.c_we0}), 32'd0);
        check("mid_rst_idle", 32'(bus3.ap_idle), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        begin_run3(1'b0);
        wait_all("after_reset");

        // N=2, ACC_W=17: 2*255*255 = 130050, ap_done in cycle 17
        @(negedge clk);
        bus2.ap_start = 1'b1;
        @(posedge clk);
        #1;
        e0 = edge_cnt;
        bus2.ap_start = 1'b0;
        for (int n = 0; n < 4; n++) exp2.push_back('{addr: n, data: 130050});
        done2.push_back(e0 + 16);
        wait_all("n2_saturate");
        check("n2_idle_end", 32'(bus2.ap_idle), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/matmul_mac_sequencer.md
Name: matmul_mac_sequencer

Overview:
- Sequences one shared unsigned 8x8->16 combinational multiplier to compute C = A x B for N x N matrices of 8-bit unsigned elements.
- Reads A and B from external single-port memories with 1-cycle read latency, accumulates each dot product, and writes each C element to an external write port.
- Uses a start/done/idle/ready block-level handshake and sits between the operand memories and the result memory in the matrix-multiply datapath.

Parameters:
- N, 3, matrix dimension; legal range 2..16.
- ACC_W, 18, accumulator and result width. Must satisfy ACC_W >= 16 + clog2(N); elaboration fails with $error otherwise.
- AW, clog2(N*N), address width of the A, B and C ports.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- ap_start  in  1  start request; sampled only in S_IDLE.
- ap_done  out  1  one-cycle pulse when the last C element has been written.
- ap_idle  out  1  high while in S_IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- a_address0  out  AW  A read address, row-major.
- a_ce0  out  1  A read enable.
- a_q0  in  8  A read data, valid 1 cycle after a_ce0.
- b_address0  out  AW  B read address, row-major.
- b_ce0  out  1  B read enable.
- b_q0  in  8  B read data, valid 1 cycle after b_ce0.
- c_address0  out  AW  C write address, row-major.
- c_ce0  out  1  C enable.
- c_we0  out  1  C write enable.
- c_d0  out  ACC_W  C write data.

Behaviour:
- Reset (asynchronous, ap_rst_n=0):
  - state=S_IDLE; i, j, k, acc and mac_v cleared to 0.
  - All ce/we, ap_done and ap_ready = 0; all addresses = 0; c_d0 = 0; ap_idle = 1.
- Reset mid-operation aborts immediately:
  - No further reads or writes.
  - C contents already written are left as they are.
- States: S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE.
- S_IDLE:
  - If ap_start=1: clear i, j, k and acc, then go to S_FETCH.
  - ap_start in any other state is ignored.
- S_FETCH:
  - Drive a_ce0 = b_ce0 = 1, a_address0 = i*N+k, b_address0 = k*N+j.
  - Set mac_v <= 1.
  - If k = N-1: go to S_DRAIN with k <= 0. Otherwise k <= k+1.
- MAC rule, applied in every state:
  - If mac_v = 1: acc <= acc + zero_extend(a_q0*b_q0), computed modulo 2^ACC_W.
  - mac_v is cleared in every state other than S_FETCH.
  - The multiplier is purely combinational; the product is used in the same cycle as the read data arrives.
- S_DRAIN: the final (k = N-1) product is accumulated; go to S_WRITE.
- S_WRITE:
  - Drive c_ce0 = c_we0 = 1, c_address0 = i*N+j, c_d0 = acc.
  - Clear acc.
  - If i = N-1 and j = N-1: go to S_DONE.
  - Else if j = N-1: j <= 0, i <= i+1, go to S_FETCH.
  - Else: j <= j+1, go to S_FETCH.
- S_DONE: ap_done = ap_ready = 1 for one cycle, then go to S_IDLE.
- Idle outputs: outside their active states, all ce/we are 0 and addresses are 0; c_d0 always reflects acc.
- Timing:
  - Each C element takes N+2 cycles (N fetch, 1 drain, 1 write).
  - ap_start is sampled at edge E0; the first fetch occurs in the cycle after E0.
  - ap_done is high in cycle N*N*(N+2)+1 after E0; for N=3 that is cycle 46.
  - ap_idle is 0 from the cycle after E0 through the ap_done cycle.
- Back-to-back operation: if ap_start is held high, the next run starts after exactly one S_IDLE cycle.
- Write order and results: C is written strictly in row-major order, each address exactly once per run. With ACC_W legal, no overflow is possible.

Decomposition:
- Shared package matmul_pkg holds:
  - The state enum (S_IDLE..S_DONE).
  - The MUL_W=16 and DATA_W=8 constants.
  - A function computing the minimum ACC_W for a given N.
- One natural sub-module, matmul_seq_mul_u8: unsigned 8x8 -> 16 combinational multiplier, zero-extended operands, no pipeline stage. It is instantiated once and is the only multiply in the block.

Test Plan:
- Identity check, N=3: A=identity, B=1..9 row-major, ap_start pulsed -> C=1..9, 9 writes to addresses 0..8 in order, ap_done high in cycle 46 only.
- Saturating operands, N=3: all A and B = 255 -> every c_d0 = 195075 (0x2FA03), no wrap with ACC_W=18.
- General values, N=3: A=[1,2,3;4,5,6;7,8,9], B=[9,8,7;6,5,4;3,2,1] -> C=[30,24,18;84,69,54;138,114,90].
- ap_start held high across two runs -> second run's first a_ce0 appears exactly 2 cycles after the first run's ap_done; ap_start pulses during busy cycles have no effect.
- Reset mid-run: assert ap_rst_n=0 in cycle 20 -> all ce/we drop asynchronously and ap_idle=1. A new start then gives a full correct C with no stale accumulator content (first element equals its true dot product).
- N=2, ACC_W=17: all operands 255 -> each C = 130050, ap_done in cycle 17; ACC_W=16 fails at elaboration.
